// File: rtl/cam_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cam_pkg : capture FSM encoding, default resolution, address sizing
// Rev 1.0
// ------------------------------------------------------------------
package cam_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS    = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_ACTIVE     = 2'd2
  } cam_state_t;

  localparam int QQVGA_W = 160;
  localparam int QQVGA_H = 120;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ------------------------------------------------------------------
// edge_det : registered copy of a level plus rise/fall strobes
// Rev 1.0
// ------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (!rst_n) r_d <= 1'b0;
    else        r_d <= d;
  end

  assign rise = ~r_d & d;
  assign fall = r_d & ~d;

endmodule
`default_nettype wire

// File: rtl/cam_px_addr_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// cam_px_addr_counter : camera byte pairing, pixel/line counters and
// framebuffer write address/strobe generation. Rev 1.0
// ------------------------------------------------------------------
module cam_px_addr_counter
  import cam_pkg::*;
#(
  parameter int H_PIXELS     = QQVGA_W,
  parameter int V_LINES      = QQVGA_H,
  parameter int BYTES_PER_PX = 2,
  parameter int ADDR_W       = addr_width(QQVGA_W, QQVGA_H)
) (
  input  logic                        pclk,
  input  logic                        in_reset,
  input  logic                        enable,
  input  logic                        vsync,
  input  logic                        href,
  output logic [$clog2(H_PIXELS)-1:0] px_cnt,
  output logic [$clog2(V_LINES)-1:0]  ln_cnt,
  output logic [ADDR_W-1:0]           addr,
  output logic                        px_we,
  output logic                        line_done,
  output logic                        frame_done,
  output logic                        ovf
);

  // Internal counters carry one extra value (H_PIXELS / V_LINES) as the saturation mark
  localparam int c_px_w = $clog2(H_PIXELS + 1);
  localparam int c_ln_w = $clog2(V_LINES + 1);
  localparam int c_bp_w = (BYTES_PER_PX > 1) ? $clog2(BYTES_PER_PX) : 1;

  cam_state_t          r_state;
  cam_state_t          w_state_next;
  logic [c_px_w-1:0]   r_px_cnt;
  logic [c_ln_w-1:0]   r_ln_cnt;
  logic [c_bp_w-1:0]   r_phase;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   w_next_base;
  logic                r_px_we;
  logic                r_line_done;
  logic                r_frame_done;
  logic                r_ovf;

  logic w_vs_rise, w_vs_fall, w_hr_fall, w_hr_rise_unused;
  logic w_last_byte, w_room;
  logic w_start, w_byte, w_store, w_drop, w_line_end, w_frame_end;

  edge_det u_vs_edge (
    .clk   (pclk),
    .rst_n (in_reset),
    .d     (vsync),
    .rise  (w_vs_rise),
    .fall  (w_vs_fall)
  );

  edge_det u_hr_edge (
    .clk   (pclk),
    .rst_n (in_reset),
    .d     (href),
    .rise  (w_hr_rise_unused),
    .fall  (w_hr_fall)
  );

  assign w_last_byte = (r_phase == c_bp_w'(BYTES_PER_PX - 1));
  assign w_room      = (r_px_cnt < c_px_w'(H_PIXELS)) && (r_ln_cnt < c_ln_w'(V_LINES));
  assign w_next_base = r_base + ADDR_W'(H_PIXELS);

  always_ff @(posedge pclk) begin
    if (!in_reset) r_state <= ST_WAIT_VS;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_byte       = 1'b0;
    w_store      = 1'b0;
    w_drop       = 1'b0;
    w_line_end   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_WAIT_VS: begin
        if (vsync) w_state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (w_vs_fall && enable) begin
          w_state_next = ST_ACTIVE;
          w_start      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_frame_end = w_vs_rise;
        w_line_end  = w_hr_fall;
        if (w_vs_rise) begin
          w_state_next = ST_WAIT_START;
        end else if (!w_hr_fall && href) begin
          w_byte = 1'b1;
          if (w_last_byte) begin
            w_store = w_room;
            w_drop  = ~w_room;
          end
        end
      end
      default: w_state_next = ST_WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!in_reset) begin
      r_px_cnt     <= '0;
      r_ln_cnt     <= '0;
      r_phase      <= '0;
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_base       <= '0;
      r_px_we      <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_px_we      <= w_store;
      r_line_done  <= w_line_end;
      r_frame_done <= w_frame_end;
      if (w_start || w_frame_end) begin
        r_px_cnt  <= '0;
        r_ln_cnt  <= '0;
        r_phase   <= '0;
        r_addr    <= '0;
        r_wr_addr <= '0;
        r_base    <= '0;
        if (w_start) r_ovf <= 1'b0;
        else if (w_line_end && r_phase != '0) r_ovf <= 1'b1;
      end else if (w_line_end) begin
        r_px_cnt <= '0;
        r_phase  <= '0;
        // Each line restarts at its own base so short lines never shift the next one
        if (r_ln_cnt < c_ln_w'(V_LINES)) begin
          r_ln_cnt  <= r_ln_cnt + c_ln_w'(1);
          r_base    <= w_next_base;
          r_wr_addr <= w_next_base;
          r_addr    <= w_next_base;
        end
        if (r_phase != '0) r_ovf <= 1'b1;
      end else if (w_byte) begin
        r_phase <= w_last_byte ? '0 : r_phase + c_bp_w'(1);
        if (w_store) begin
          r_addr    <= r_wr_addr;
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
          r_px_cnt  <= r_px_cnt + c_px_w'(1);
        end
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  assign px_cnt     = r_px_cnt[$clog2(H_PIXELS)-1:0];
  assign ln_cnt     = r_ln_cnt[$clog2(V_LINES)-1:0];
  assign addr       = r_addr;
  assign px_we      = r_px_we;
  assign line_done  = r_line_done;
  assign frame_done = r_frame_done;
  assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cam_px_addr_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cam_px_addr_counter : frame-level stimulus against a line/byte model
// Rev 1.0
// ------------------------------------------------------------------
module tb_cam_px_addr_counter;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int B  = 2;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          in_reset = 1'b0;
  logic          enable = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [1:0]    px_cnt;
  logic [1:0]    ln_cnt;
  logic [AW-1:0] addr;
  logic          px_we, line_done, frame_done, ovf;

  int errors = 0;
  int checks = 0;

  cam_px_addr_counter #(
    .H_PIXELS     (H),
    .V_LINES      (V),
    .BYTES_PER_PX (B),
    .ADDR_W       (AW)
  ) dut (
    .pclk       (pclk),
    .in_reset   (in_reset),
    .enable     (enable),
    .vsync      (vsync),
    .href       (href),
    .px_cnt     (px_cnt),
    .ln_cnt     (ln_cnt),
    .addr       (addr),
    .px_we      (px_we),
    .line_done  (line_done),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 pclk = ~pclk;

  // Observed write stream and pulse counts
  int got_addr[$];
  int n_ld = 0;
  int n_fd = 0;
  always @(negedge pclk) begin
    if (in_reset) begin
      if (px_we)      got_addr.push_back(int'(addr));
      if (line_done)  n_ld++;
      if (frame_done) n_fd++;
    end
  end

  // Frame description and expected results
  int lens[8];
  int nl;
  int exp_q[$];
  int exp_ovf, exp_ld, exp_fd, exp_ln;
  int last_ovf = 0;

  typedef struct {
    bit en;
    int nl;
    int l0, l1, l2, l3;
    int we, ld, fd;
    int ov;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Each line l < V stores pixel k at l*H+k for k < H; anything else is overflow
  function automatic void model(input bit en);
    int p;
    exp_q.delete();
    exp_ld = 0;
    exp_fd = 0;
    exp_ln = 0;
    if (!en) begin
      exp_ovf = last_ovf;
      return;
    end
    exp_ovf = 0;
    exp_fd  = 1;
    exp_ld  = nl;
    exp_ln  = (nl < V) ? nl : V;
    for (int l = 0; l < nl; l++) begin
      p = lens[l] / B;
      if (lens[l] % B != 0) exp_ovf = 1;
      for (int k = 0; k < p; k++) begin
        if (l < V && k < H) exp_q.push_back(l * H + k);
        else exp_ovf = 1;
      end
    end
    last_ovf = exp_ovf;
  endfunction

  task automatic run_frame(input bit en, input bit en_mid);
    int n;
    model(en);
    got_addr.delete();
    n_ld = 0;
    n_fd = 0;
    vsync  = 1'b1;
    enable = en;
    tick(2);
    vsync = 1'b0;
    tick(1);
    enable = en_mid;
    tick(2);
    for (int l = 0; l < nl; l++) begin
      href = 1'b1;
      tick(lens[l]);
      href = 1'b0;
      tick(3);
    end
    check("ln_cnt_end", int'(ln_cnt), exp_ln);
    check("px_cnt_end", int'(px_cnt), 0);
    vsync = 1'b1;
    tick(4);
    check("px_we_count", got_addr.size(), exp_q.size());
    n = (got_addr.size() < exp_q.size()) ? got_addr.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("addr_seq", got_addr[i], exp_q[i]);
    check("line_done_count", n_ld, exp_ld);
    check("frame_done_count", n_fd, exp_fd);
    check("ovf", int'(ovf), exp_ovf);
    check("addr_cleared", int'(addr), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_px_cnt"}, int'(px_cnt), 0);
    check({tag, "_ln_cnt"}, int'(ln_cnt), 0);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_px_we"}, int'(px_we), 0);
    check({tag, "_line_done"}, int'(line_done), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    tbl[0] = '{en: 1'b1, nl: 3, l0: 8,  l1: 8, l2: 8, l3: 0, we: 12, ld: 3, fd: 1, ov: 0};
    tbl[1] = '{en: 1'b1, nl: 3, l0: 10, l1: 8, l2: 8, l3: 0, we: 12, ld: 3, fd: 1, ov: 1};
    tbl[2] = '{en: 1'b1, nl: 3, l0: 5,  l1: 8, l2: 8, l3: 0, we: 10, ld: 3, fd: 1, ov: 1};
    tbl[3] = '{en: 1'b1, nl: 4, l0: 8,  l1: 8, l2: 8, l3: 8, we: 12, ld: 4, fd: 1, ov: 1};
    tbl[4] = '{en: 1'b0, nl: 3, l0: 8,  l1: 8, l2: 8, l3: 0, we: 0,  ld: 0, fd: 0, ov: 1};
    tbl[5] = '{en: 1'b1, nl: 3, l0: 8,  l1: 8, l2: 8, l3: 0, we: 12, ld: 3, fd: 1, ov: 0};

    // Power-up reset
    tick(3);
    check_idle("reset");
    in_reset = 1'b1;
    tick(2);

    foreach (tbl[i]) begin
      nl      = tbl[i].nl;
      lens[0] = tbl[i].l0;
      lens[1] = tbl[i].l1;
      lens[2] = tbl[i].l2;
      lens[3] = tbl[i].l3;
      run_frame(tbl[i].en, tbl[i].en);
      check("tbl_px_we", got_addr.size(), tbl[i].we);
      check("tbl_line_done", n_ld, tbl[i].ld);
      check("tbl_frame_done", n_fd, tbl[i].fd);
      check("tbl_ovf", int'(ovf), tbl[i].ov);
    end

    // HREF fall and VSYNC rise on the same edge
    vsync  = 1'b1;
    enable = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
    href = 1'b1;
    tick(4);
    href  = 1'b0;
    vsync = 1'b1;
    tick(1);
    check("coincident_line_done", int'(line_done), 1);
    check("coincident_frame_done", int'(frame_done), 1);
    tick(3);
    check("coincident_ovf", int'(ovf), 0);
    last_ovf = 0;

    // Reset in the middle of a captured line, then an uncaptured line
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
    href = 1'b1;
    tick(3);
    in_reset = 1'b0;
    tick(3);
    check_idle("midline_reset");
    in_reset = 1'b1;
    got_addr.delete();
    n_ld = 0;
    tick(5);
    href = 1'b0;
    tick(3);
    href = 1'b1;
    tick(8);
    href = 1'b0;
    tick(3);
    check("post_reset_no_px_we", got_addr.size(), 0);
    check("post_reset_no_line_done", n_ld, 0);
    last_ovf = 0;
    nl      = 3;
    lens[0] = 8;
    lens[1] = 8;
    lens[2] = 8;
    run_frame(1'b1, 1'b1);

    // Randomized frames: line count, byte counts and enable all vary
    for (int f = 0; f < 30; f++) begin
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) lens[l] = $urandom_range(1, 12);
      run_frame($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_px_addr_counter.md
Name: cam_px_addr_counter

Overview:
Parametrised successor of the per-line pixel counter in the OV7670 capture path. Runs on the camera pixel clock, tracks VSYNC/HREF framing, pairs incoming bytes into pixels, and produces pixel/line counters, a linear framebuffer write address and a one-cycle write strobe. Sits between the camera byte interface and the framebuffer RAM write port. Fully synchronous, with no combinational feedback loops.

Parameters:
H_PIXELS, 160, pixels stored per line; excess pixels in a line are dropped
V_LINES, 120, lines stored per frame; excess lines are dropped
BYTES_PER_PX, 2, camera bytes per pixel (2 = RGB565/RGB444, 1 = grey/Y only)
ADDR_W, 15, framebuffer address width; must satisfy 2**ADDR_W >= H_PIXELS*V_LINES

Ports:
pclk  in  1  camera pixel clock; the only clock
in_reset  in  1  synchronous, active-low reset (0 = reset)
enable  in  1  capture arm; sampled only at frame start
vsync  in  1  camera VSYNC; high = vertical blanking
href  in  1  camera HREF; high = valid byte on this pclk edge
px_cnt  out  $clog2(H_PIXELS)  pixel index within current line
ln_cnt  out  $clog2(V_LINES)  line index within current frame
addr  out  ADDR_W  framebuffer write address = ln_cnt*H_PIXELS + px_cnt
px_we  out  1  one-cycle pulse: pixel complete, addr valid
line_done  out  1  one-cycle pulse on HREF falling edge during capture
frame_done  out  1  one-cycle pulse on VSYNC rising edge ending a captured frame
ovf  out  1  sticky per frame: line or frame exceeded H_PIXELS/V_LINES, or partial pixel at line end

Behaviour:
- Reset (in_reset==0 on a pclk edge): all outputs 0, byte phase 0, vsync_d/href_d 0, FSM to WAIT_VS. Reset wins over every other event in the same cycle.
- Edge detection uses registered vsync_d and href_d. vs_fall = vsync_d & ~vsync. vs_rise = ~vsync_d & vsync. hr_fall = href_d & ~href.
- FSM WAIT_VS: wait for vsync==1, then go to WAIT_START. This ensures capture never starts mid-frame after reset.
- FSM WAIT_START: on vs_fall with enable==1, go to ACTIVE. Counters, byte phase and ovf are 0 on entry. If enable==0 at vs_fall, stay in WAIT_START.
- FSM ACTIVE, href==1: byte phase increments modulo BYTES_PER_PX. On the last byte of a pixel:
  - if px_cnt < H_PIXELS and ln_cnt < V_LINES: px_we=1 in the next cycle with addr = current pixel address; px_cnt increments in the same cycle.
  - otherwise: no px_we, set ovf, counters hold (saturate).
- Latency: px_we and addr appear 1 pclk after the last byte edge.
- px_cnt ranges 0..H_PIXELS; the value H_PIXELS marks a full line. addr is maintained incrementally (+1 per pixel) with no multiplier.
- ACTIVE, hr_fall:
  - line_done=1; px_cnt=0; byte phase=0.
  - ln_cnt increments, saturating at V_LINES; reaching saturation sets ovf on the next stored-pixel attempt.
  - If byte phase!=0 at hr_fall, the partial pixel is discarded and ovf is set.
  - addr resyncs to (ln_cnt+1)*H_PIXELS (running line-base register + H_PIXELS). Short lines therefore do not shift later lines.
- ACTIVE, vs_rise:
  - frame_done=1; counters, byte phase and addr clear; FSM goes to WAIT_START.
  - ovf holds until the next frame start.
  - A vs_rise coincident with hr_fall: line_done and frame_done both pulse in the same cycle.
- vs_fall in ACTIVE without a preceding vs_rise (glitch): ignored.
- enable deasserted mid-frame: the current frame completes; the change is honoured at the next vs_fall.

Decomposition:
- Shared package cam_pkg:
  - FSM state encoding (WAIT_VS, WAIT_START, ACTIVE).
  - Default resolution constants QQVGA_W=160, QQVGA_H=120.
  - Function addr_width(w,h).
- One natural sub-module, edge_det: registered rise/fall detector, instantiated for vsync and href.

Test Plan:
- Reset: in_reset=0 for 3 cycles mid-line -> all outputs 0, FSM WAIT_VS. The next frame is not captured until vsync goes 1 then 0.
- Nominal frame (H_PIXELS=4, V_LINES=3, BYTES_PER_PX=2): 3 lines of 8 bytes.
  - 12 px_we pulses, addr 0..11 in order.
  - 3 line_done pulses; 1 frame_done on vs_rise.
  - ovf=0.
- Long line: 10 bytes on line 0 -> addr 0..3 written, 5th pixel dropped, ovf=1. Line 1 starts at addr 4.
- Short and odd line: line 0 has 5 bytes -> 2 px_we (addr 0,1); partial byte discarded; ovf=1. Line 1 starts at addr 4.
- Extra lines: 4 lines sent -> 12 px_we total, none for line 3, ovf=1, ln_cnt stays 3.
- enable=0 at vs_fall -> no px_we or frame_done for that frame. With enable=1 at the next vs_fall, capture resumes at addr 0.
